// File: rtl/shift_rows_pipe.sv
// shift_rows_pipe: pipelined ShiftRows/InvShiftRows for NB=4/6/8 with valid/ready handshake.
// Optional macro SHIFT_ROWS_PIPE_STATS_EN adds the xfer_count output-transfer counter.
module shift_rows_pipe #(
    parameter int NB          = 4,
    parameter int PIPE_STAGES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_inv,
    input  logic [32*NB-1:0] in_state,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [32*NB-1:0] out_state
`ifdef SHIFT_ROWS_PIPE_STATS_EN
    ,
    output logic [31:0]      xfer_count
`endif
);
    localparam int W = 32 * NB;
    localparam int L = PIPE_STAGES - 1;

    if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
        $error("shift_rows_pipe: NB must be 4, 6 or 8");
    end
    if (PIPE_STAGES < 1 || PIPE_STAGES > 4) begin : g_bad_stages
        $error("shift_rows_pipe: PIPE_STAGES must be in 1..4");
    end

    logic [W-1:0]           perm;
    logic [W-1:0]           data [PIPE_STAGES];
    logic [PIPE_STAGES-1:0] valid;
    logic [PIPE_STAGES-1:0] adv;

    // Source column for output (c, r); the 256-bit block skips offset 2 on rows 2 and 3.
    function automatic int src_col(input int c, input int r, input logic inv);
        int off;
        off = (NB == 8 && r >= 2) ? r + 1 : r;
        return inv ? (c + NB - off) % NB : (c + off) % NB;
    endfunction

    // Byte permutation of the incoming state, direction chosen by in_inv.
    always_comb begin
        perm = '0;
        for (int c = 0; c < NB; c++)
            for (int r = 0; r < 4; r++)
                perm[8*(4*c+r) +: 8] = in_state[8*(4*src_col(c, r, in_inv)+r) +: 8];
    end

    // Ready chain from the output back: a stage advances when empty or its successor advances.
    always_comb begin
        adv    = '0;
        adv[L] = !valid[L] || out_ready;
        for (int k = L - 1; k >= 0; k--)
            adv[k] = !valid[k] || adv[k+1];
    end

    // Stage 0 captures the permuted input; later stages forward valid and data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
            for (int k = 0; k < PIPE_STAGES; k++)
                data[k] <= '0;
        end else begin
            if (adv[0]) begin
                valid[0] <= in_valid;
                data[0]  <= perm;
            end
            for (int k = 1; k < PIPE_STAGES; k++)
                if (adv[k]) begin
                    valid[k] <= valid[k-1];
                    data[k]  <= data[k-1];
                end
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = valid[L];
    assign out_state = data[L];

`ifdef SHIFT_ROWS_PIPE_STATS_EN
    // Count output transfers; wraps naturally at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            xfer_count <= '0;
        else if (out_valid && out_ready)
            xfer_count <= xfer_count + 32'd1;
    end
`endif

endmodule

// File: tb/tb_shift_rows_pipe.sv
// tb_shift_rows_pipe: directed self-checking bench for shift_rows_pipe (NB=4/8, 1..3 stages).
module tb_shift_rows_pipe;
    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic         a_iv, a_ir, a_inv, a_ov, a_or;
    logic [127:0] a_in, a_out;
    logic         b_iv, b_ir, b_inv, b_ov, b_or;
    logic [255:0] b_in, b_out;
    logic         c_iv, c_ir, c_inv, c_ov, c_or;
    logic [127:0] c_in, c_out;
`ifdef SHIFT_ROWS_PIPE_STATS_EN
    logic [31:0]  a_xc, b_xc, c_xc;
`endif

    shift_rows_pipe #(.NB(4), .PIPE_STAGES(1)) u_a (
        .clk(clk), .rst(rst_a), .in_valid(a_iv), .in_ready(a_ir), .in_inv(a_inv),
        .in_state(a_in), .out_valid(a_ov), .out_ready(a_or), .out_state(a_out)
`ifdef SHIFT_ROWS_PIPE_STATS_EN
        , .xfer_count(a_xc)
`endif
    );

    shift_rows_pipe #(.NB(8), .PIPE_STAGES(3)) u_b (
        .clk(clk), .rst(rst_b), .in_valid(b_iv), .in_ready(b_ir), .in_inv(b_inv),
        .in_state(b_in), .out_valid(b_ov), .out_ready(b_or), .out_state(b_out)
`ifdef SHIFT_ROWS_PIPE_STATS_EN
        , .xfer_count(b_xc)
`endif
    );

    shift_rows_pipe #(.NB(4), .PIPE_STAGES(2)) u_c (
        .clk(clk), .rst(rst_a), .in_valid(c_iv), .in_ready(c_ir), .in_inv(c_inv),
        .in_state(c_in), .out_valid(c_ov), .out_ready(c_or), .out_state(c_out)
`ifdef SHIFT_ROWS_PIPE_STATS_EN
        , .xfer_count(c_xc)
`endif
    );

    task automatic chk(input string tag, input logic [263:0] got, input logic [263:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    localparam logic [127:0] FWD4 = 128'h0B06010C_07020D08_030E0904_0F0A0500;
    localparam logic [127:0] INV4 = 128'h0306090C_0F020508_0B0E0104_070A0D00;
    localparam logic [255:0] FWD8 = 256'h0F0A011C_0B061D18_07021914_031E1510_1F1A110C_1B160D08_17120904_130E0500;

    initial begin
        logic [127:0] cnt4;
        logic [255:0] cnt8;
        logic [255:0] v [5];
        logic [127:0] q [$];
        logic [127:0] held;
        logic         acc, drn, stall;
        int           sent, got;
        {a_iv, a_inv, a_or, b_iv, b_inv, b_or, c_iv, c_inv, c_or} = '0;
        a_in = '0;
        b_in = '0;
        c_in = '0;
        for (int i = 0; i < 32; i++) begin
            cnt8[8*i +: 8] = 8'(i);
            if (i < 16) cnt4[8*i +: 8] = 8'(i);
        end
        for (int i = 0; i < 5; i++)
            v[i] = {8{32'hA3A2A1A0 + 32'(i)}};

        tick;
        tick;
        chk("rst_a_ov", a_ov, 0);
        chk("rst_a_ir", a_ir, 1);
        chk("rst_b_out", {b_ov, b_out}, 0);
        chk("rst_b_ir", b_ir, 1);
`ifdef SHIFT_ROWS_PIPE_STATS_EN
        chk("rst_xc", b_xc, 0);
`endif
        rst_a = 1'b0;
        rst_b = 1'b0;

        // NB=4, one stage: forward, inverse, round trip
        a_or = 1'b1; a_iv = 1'b1; a_inv = 1'b0; a_in = cnt4;
        tick;
        chk("t1_fwd", {a_ov, a_out}, {1'b1, FWD4});
        a_inv = 1'b1; a_in = cnt4;
        tick;
        chk("t2_inv", {a_ov, a_out}, {1'b1, INV4});
        a_in = FWD4;
        tick;
        chk("t2_round", {a_ov, a_out}, {1'b1, cnt4});
        a_iv = 1'b0;
        tick;
        chk("t1_idle", a_ov, 0);

        // NB=8, three stages: latency, forward, inverse
        b_or = 1'b1; b_iv = 1'b1; b_inv = 1'b0; b_in = cnt8;
        tick;
        b_iv = 1'b0;
        chk("t3_lat1", b_ov, 0);
        tick;
        chk("t3_lat2", b_ov, 0);
        tick;
        chk("t3_fwd", {b_ov, b_out}, {1'b1, FWD8});
        chk("t3_col0", b_out[31:0], 32'h130E0500);
        b_iv = 1'b1; b_inv = 1'b1; b_in = FWD8;
        tick;
        b_iv = 1'b0;
        tick;
        tick;
        chk("t3_inv", {b_ov, b_out}, {1'b1, cnt8});
        tick;
        chk("t3_idle", b_ov, 0);

        // Reset between tests clears the counter
        rst_b = 1'b1;
        #1;
`ifdef SHIFT_ROWS_PIPE_STATS_EN
        chk("t4_xc0", b_xc, 0);
`endif
        chk("t4_rst_ov", b_ov, 0);
        rst_b = 1'b0;

        // Backpressure fill, then simultaneous enter/leave and ordered drain
        b_or = 1'b0; b_iv = 1'b1;
        for (int i = 0; i < 3; i++) begin
            b_in = v[i]; b_inv = 1'(i);
            #1;
            chk("t4_ready", b_ir, 1);
            tick;
        end
        b_in = v[3]; b_inv = 1'b1;
        #1;
        chk("t4_full", b_ir, 0);
        chk("t4_head", {b_ov, b_out}, {1'b1, v[0]});
        tick;
        chk("t4_still_full", b_ir, 0);
        chk("t4_stable", {b_ov, b_out}, {1'b1, v[0]});
        b_or = 1'b1;
        #1;
        chk("t4_simul", b_ir, 1);
        tick;
        b_in = v[4]; b_inv = 1'b0;
        chk("t4_out_b", {b_ov, b_out}, {1'b1, v[1]});
        tick;
        b_iv = 1'b0;
        chk("t4_out_c", {b_ov, b_out}, {1'b1, v[2]});
        tick;
        chk("t4_out_d", {b_ov, b_out}, {1'b1, v[3]});
        tick;
        chk("t4_out_e", {b_ov, b_out}, {1'b1, v[4]});
        tick;
        chk("t4_empty", b_ov, 0);
`ifdef SHIFT_ROWS_PIPE_STATS_EN
        chk("t4_xc5", b_xc, 5);
`endif

        // Asynchronous reset with two transactions in flight
        b_or = 1'b0; b_iv = 1'b1; b_in = v[0];
        tick;
        b_in = v[1];
        tick;
        b_iv = 1'b0;
        tick;
        chk("t6_pre", b_ov, 1);
        rst_b = 1'b1;
        #1;
        chk("t6_rst", {b_ov, b_out}, 0);
        chk("t6_ir", b_ir, 1);
`ifdef SHIFT_ROWS_PIPE_STATS_EN
        chk("t6_xc0", b_xc, 0);
`endif
        rst_b = 1'b0;
        b_or = 1'b1; b_iv = 1'b1; b_in = v[2];
        tick;
        b_iv = 1'b0;
        chk("t6_lat1", b_ov, 0);
        tick;
        chk("t6_lat2", b_ov, 0);
        tick;
        chk("t6_new", {b_ov, b_out}, {1'b1, v[2]});
        tick;
        chk("t6_drained", b_ov, 0);
`ifdef SHIFT_ROWS_PIPE_STATS_EN
        chk("t6_xc1", b_xc, 1);
`endif

        // Two stages, continuous input, toggling out_ready
        sent = 0;
        got = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            c_or = (cyc % 2) == 0;
            c_iv = sent < 10;
            c_inv = sent[0];
            c_in = {4{32'hC0DE0000 + 32'(sent)}};
            #1;
            acc = c_iv && c_ir;
            drn = c_ov && c_or;
            stall = c_ov && !c_or;
            held = c_out;
            if (drn) begin
                chk("t5_nonempty", q.size() > 0, 1);
                if (q.size() > 0) chk("t5_data", c_out, q.pop_front());
                got++;
            end
            if (acc) begin
                q.push_back(c_in);
                sent++;
            end
            @(posedge clk);
            #1;
            if (stall) chk("t5_hold", {c_ov, c_out}, {1'b1, held});
        end
        chk("t5_count", got, 10);
        chk("t5_left", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/shift_rows_pipe.md
Name: shift_rows_pipe

Overview:
Parametrised, pipelined ShiftRows / InvShiftRows stage for the round datapath. It generalises the fixed 4-column, encrypt-only, combinational permutation in three ways:
- supports Rijndael block widths NB = 4/6/8 columns;
- selects the direction per transaction;
- registers the result through a configurable-depth pipeline with a valid/ready handshake.

It sits between the SubBytes and MixColumns stages and can absorb backpressure without losing data.

Parameters:
NB, 4, number of state columns; legal values 4, 6, 8; state width W = 32*NB bits
PIPE_STAGES, 1, number of register stages; legal range 1..4; equals the latency in cycles

Ports:
clk  input  1  clock, rising-edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  input transaction present
in_ready  output  1  block can accept input this cycle
in_inv  input  1  0 = ShiftRows (encrypt), 1 = InvShiftRows (decrypt); sampled with in_valid
in_state  input  W  input state; byte i at bits [8*i+7:8*i]; i = 4*col + row
out_valid  output  1  output transaction present
out_ready  input  1  downstream accepts output
out_state  output  W  permuted state, same byte layout

Behaviour:
- Transfer rules: input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
- Row offsets (off_r, rows 0..3):
  - NB=4 or 6: 0,1,2,3.
  - NB=8: 0,1,3,4.
- Forward permutation: out byte(4c+r) = in byte(4*((c+off_r) mod NB)+r).
- Inverse permutation: out byte(4c+r) = in byte(4*((c-off_r+NB) mod NB)+r).
- The permutation is combinational on in_state, selected by in_inv, and lands in stage 0's register. Later stages carry data and valid only.
- Stage k holds {valid_k, data_k}. Stage k loads when it is empty or its contents leave this cycle. The last stage's contents leave on an output transfer.
- in_ready = !valid_0 || stage 0 advances this cycle. This is a per-stage ready chain, so bubbles collapse: an empty middle stage never blocks an upstream stage.
- out_valid = valid_(PIPE_STAGES-1); out_state = data_(PIPE_STAGES-1).
- Latency and throughput: latency is exactly PIPE_STAGES cycles from input transfer to out_valid when out_ready is held high. Throughput is 1 transaction/cycle.
- Order and integrity: transactions leave in acceptance order, with no drop and no duplication.
- Backpressure: with out_ready=0, the pipe fills. in_ready deasserts in the cycle after the PIPE_STAGES-th accepted transaction, once all stages are full.
- Full pipe, simultaneous events: in the same cycle as out_ready rises, in_ready=1 and one item enters while one leaves.
- Output stability: while out_valid=1 && out_ready=0, out_state and out_valid hold stable.
- Upstream protocol: in_valid may be deasserted at any time. in_state and in_inv changes while not accepted are ignored.
- Reset: all valid_k clear asynchronously; out_valid=0, in_ready=1, data registers=0, out_state=0.
  - A reset mid-stream discards all in-flight transactions.
  - The first acceptance is in the first clk edge after rst deasserts.
- Illegal parameters: an NB outside {4,6,8} or PIPE_STAGES outside 1..4 must trigger an elaboration-time error.

Optional Feature:
Macro SHIFT_ROWS_PIPE_STATS_EN.
- Defined: adds output port xfer_count (output, 32 bits), which counts output transfers.
  - Reset value 0.
  - Increments by 1 per output transfer.
  - Wraps 0xFFFFFFFF -> 0.
  - Cleared by rst.
- Not defined: the port and the counter do not exist. All other behaviour is identical.

Test Plan:
1. NB=4, PIPE_STAGES=1, forward, in_state bytes i=0..15 (0x0F0E0D0C_0B0A0908_07060504_03020100), out_ready=1 -> after 1 cycle, out_state = 0x0B06010C_07020D08_030E0904_0F0A0500 (bytes 00 05 0A 0F 04 09 0E 03 08 0D 02 07 0C 01 06 0B).
2. NB=4, inverse, same counting input -> out_state bytes 00 0D 0A 07 04 01 0E 0B 08 05 02 0F 0C 09 06 03. Feeding the test 1 output with in_inv=1 returns 0x0F0E0D0C_0B0A0908_07060504_03020100.
3. NB=8, forward, byte i = i (0x00..0x1F) -> column 0 of the output is bytes 0x00,0x05,0x0E,0x13. Inverse of the result restores the input.
4. PIPE_STAGES=3, out_ready=0, stream 5 transactions A..E -> A,B,C accepted; in_ready=0 from the next cycle. Raise out_ready -> outputs A,B,C,D,E in order, one per cycle, no gaps.
5. PIPE_STAGES=2, continuous input with out_ready toggling 1,0,1,0 -> no loss or duplication; out_state stable during each stall cycle.
6. Assert rst with 2 transactions in flight -> out_valid=0 and in_ready=1 immediately (asynchronous). After release, a new transaction emerges after PIPE_STAGES cycles. With SHIFT_ROWS_PIPE_STATS_EN, xfer_count is 0 after reset and 5 after test 4.
